// File: rtl/amo_bank_arbiter.sv
// Round-robin arbiter sharing one AMO-capable SRAM bank among NumIn masters; read response returns 1 cycle after grant.
// Backpressure: grants only when the shim grants; every request is blocked during the 1-cycle AMO write-back.
module amo_bank_arbiter #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 32,
    localparam int unsigned IdxWidth    = $clog2(NumIn)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NumIn-1:0]                         in_req_i,
    output logic [NumIn-1:0]                         in_gnt_o,
    input  logic [NumIn-1:0][AddrMemWidth-1:0]       in_add_i,
    input  logic [NumIn-1:0][3:0]                    in_amo_i,
    input  logic [NumIn-1:0]                         in_wen_i,
    input  logic [NumIn-1:0][DataWidth-1:0]          in_wdata_i,
    input  logic [NumIn-1:0][DataWidth/8-1:0]        in_be_i,
    output logic [NumIn-1:0]                         in_rvalid_o,
    output logic [DataWidth-1:0]                     in_rdata_o,
    output logic                                     out_req_o,
    input  logic                                     out_gnt_i,
    output logic [AddrMemWidth-1:0]                  out_add_o,
    output logic [3:0]                               out_amo_o,
    output logic                                     out_wen_o,
    output logic [DataWidth-1:0]                     out_wdata_o,
    output logic [DataWidth/8-1:0]                   out_be_o,
    input  logic [DataWidth-1:0]                     out_rdata_i
);

    typedef enum logic {
        Idle      = 1'b0,
        AmoCommit = 1'b1
    } state_e;

    localparam logic [IdxWidth:0]   NumInW = (IdxWidth+1)'(NumIn);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 1);

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] rr_q, rr_d;
    logic                resp_valid_q, resp_valid_d;
    logic [IdxWidth-1:0] resp_idx_q, resp_idx_d;

    logic [IdxWidth-1:0] sel;
    logic [IdxWidth:0]   idx_ext;
    logic                found;
    logic                grant;

    // First requester at or after the priority pointer, wrapping modulo NumIn.
    always_comb begin
        sel     = rr_q;
        found   = 1'b0;
        idx_ext = '0;
        for (int k = 0; k < NumIn; k++) begin
            idx_ext = {1'b0, rr_q} + (IdxWidth+1)'(k);
            if (idx_ext >= NumInW) begin
                idx_ext = idx_ext - NumInW;
            end
            if (!found && in_req_i[idx_ext[IdxWidth-1:0]]) begin
                sel   = idx_ext[IdxWidth-1:0];
                found = 1'b1;
            end
        end
    end

    assign out_add_o   = in_add_i[sel];
    assign out_amo_o   = in_amo_i[sel];
    assign out_wen_o   = in_wen_i[sel];
    assign out_wdata_o = in_wdata_i[sel];
    assign out_be_o    = in_be_i[sel];

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        resp_valid_d = 1'b0;
        resp_idx_d   = resp_idx_q;
        out_req_o    = 1'b0;
        in_gnt_o     = '0;
        grant        = 1'b0;
        unique case (state_q)
            Idle: begin
                out_req_o = rst_ni & (|in_req_i);
                grant     = out_req_o & out_gnt_i;
                if (grant) begin
                    in_gnt_o[sel] = 1'b1;
                    rr_d          = (sel == LastIdx) ? '0 : sel + 1'b1;
                    resp_valid_d  = 1'b1;
                    resp_idx_d    = sel;
                    if (in_amo_i[sel] != 4'd0) begin
                        state_d = AmoCommit;
                    end
                end
            end
            // Shim is writing the AMO result back; the bank port is busy.
            AmoCommit: begin
                state_d = Idle;
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= Idle;
            rr_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            resp_valid_q <= resp_valid_d;
            resp_idx_q   <= resp_idx_d;
        end
    end

    always_comb begin
        in_rvalid_o             = '0;
        in_rvalid_o[resp_idx_q] = resp_valid_q;
    end

    assign in_rdata_o = out_rdata_i;

endmodule

// File: tb/tb_amo_bank_arbiter.sv
// Directed bench for amo_bank_arbiter with a small bank model that answers one cycle after grant.
module tb_amo_bank_arbiter;

    logic             clk;
    logic             rst_n;
    logic [3:0]       in_req;
    logic [3:0]       in_gnt;
    logic [3:0][31:0] in_add;
    logic [3:0][3:0]  in_amo;
    logic [3:0]       in_wen;
    logic [3:0][31:0] in_wdata;
    logic [3:0][3:0]  in_be;
    logic [3:0]       in_rvalid;
    logic [31:0]      in_rdata;
    logic             out_req;
    logic             out_gnt;
    logic [31:0]      out_add;
    logic [3:0]       out_amo;
    logic             out_wen;
    logic [31:0]      out_wdata;
    logic [3:0]       out_be;
    logic [31:0]      out_rdata;

    int tests_run;
    int tests_failed;

    amo_bank_arbiter #(.NumIn(4), .AddrMemWidth(32), .DataWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_amo_i(in_amo),
        .in_wen_i(in_wen), .in_wdata_i(in_wdata), .in_be_i(in_be),
        .in_rvalid_o(in_rvalid), .in_rdata_o(in_rdata),
        .out_req_o(out_req), .out_gnt_i(out_gnt), .out_add_o(out_add), .out_amo_o(out_amo),
        .out_wen_o(out_wen), .out_wdata_o(out_wdata), .out_be_o(out_be), .out_rdata_i(out_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: read data one cycle after a grant; an AMO returns the old value and adds wdata.
    logic [31:0] mem [64];
    logic [31:0] merged;
    always @(posedge clk) begin
        if (out_req && out_gnt) begin
            out_rdata <= mem[out_add[5:0]];
            if (out_amo != 4'd0) begin
                mem[out_add[5:0]] <= mem[out_add[5:0]] + out_wdata;
            end else if (out_wen) begin
                merged = mem[out_add[5:0]];
                for (int b = 0; b < 4; b++) begin
                    if (out_be[b]) merged[b*8 +: 8] = out_wdata[b*8 +: 8];
                end
                mem[out_add[5:0]] <= merged;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] amo_mask;
        logic       ogn;
        logic       ereq;
        logic [3:0] egnt;
        logic [3:0] erv;
        logic [1:0] err;
    } vec_t;

    vec_t vecs[17];

    task automatic idle_payload();
        for (int m = 0; m < 4; m++) begin
            in_add[m]   = 32'h20 + 32'(m);
            in_amo[m]   = 4'd0;
            in_wen[m]   = 1'b0;
            in_wdata[m] = 32'h0;
            in_be[m]    = 4'hF;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        // req, amo_mask, out_gnt, exp out_req, exp gnt, exp rvalid, exp rr_q
        vecs[0]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h1, 4'h0, 2'd0};
        vecs[1]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h2, 4'h1, 2'd1};
        vecs[2]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h4, 4'h2, 2'd2};
        vecs[3]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h8, 4'h4, 2'd3};
        vecs[4]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h1, 4'h8, 2'd0};
        vecs[5]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1, 2'd1};
        vecs[6]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 2'd1};
        vecs[7]  = '{4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 2'd1};
        vecs[8]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h2, 4'h0, 2'd1};
        vecs[9]  = '{4'h4, 4'h0, 1'b1, 1'b1, 4'h4, 4'h2, 2'd2};
        vecs[10] = '{4'hA, 4'h0, 1'b1, 1'b1, 4'h8, 4'h4, 2'd3};
        vecs[11] = '{4'h2, 4'h0, 1'b1, 1'b1, 4'h2, 4'h8, 2'd0};
        vecs[12] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h2, 2'd2};
        vecs[13] = '{4'h5, 4'h4, 1'b1, 1'b1, 4'h4, 4'h0, 2'd2};
        vecs[14] = '{4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 4'h4, 2'd3};
        vecs[15] = '{4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 4'h0, 2'd3};
        vecs[16] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h1, 2'd1};

        // Reset: requests present but out_req must stay low, payload follows master 0.
        rst_n   = 1'b0;
        in_req  = 4'hF;
        out_gnt = 1'b1;
        idle_payload();
        repeat (2) @(negedge clk);
        check("rst_out_req", 64'(out_req), 64'd0);
        check("rst_gnt", 64'(in_gnt), 64'd0);
        check("rst_rvalid", 64'(in_rvalid), 64'd0);
        check("rst_out_add", 64'(out_add), 64'h20);
        out_gnt = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            in_req  = vecs[i].req;
            out_gnt = vecs[i].ogn;
            for (int m = 0; m < 4; m++) in_amo[m] = vecs[i].amo_mask[m] ? 4'h2 : 4'h0;
            @(negedge clk);
            check($sformatf("v%0d_out_req", i), 64'(out_req), 64'(vecs[i].ereq));
            check($sformatf("v%0d_gnt", i), 64'(in_gnt), 64'(vecs[i].egnt));
            check($sformatf("v%0d_rvalid", i), 64'(in_rvalid), 64'(vecs[i].erv));
            check($sformatf("v%0d_rr", i), 64'(dut.rr_q), 64'(vecs[i].err));
        end

        // Store then load through different masters, then AMO add on the same word.
        @(posedge clk); #1;
        idle_payload();
        in_req = 4'h2; in_wen[1] = 1'b1; in_add[1] = 32'h10; in_wdata[1] = 32'hDEADBEEF;
        @(negedge clk);
        check("st_gnt", 64'(in_gnt), 64'h2);
        @(posedge clk); #1;
        in_req = 4'h8; in_wen[1] = 1'b0; in_add[3] = 32'h10;
        @(negedge clk);
        check("st_rvalid", 64'(in_rvalid), 64'h2);
        check("ld_gnt", 64'(in_gnt), 64'h8);
        @(posedge clk); #1;
        in_req = 4'h4; in_amo[2] = 4'h2; in_add[2] = 32'h10; in_wdata[2] = 32'h1;
        @(negedge clk);
        check("ld_rvalid", 64'(in_rvalid), 64'h8);
        check("ld_rdata", 64'(in_rdata), 64'hDEADBEEF);
        check("amo_gnt", 64'(in_gnt), 64'h4);
        @(posedge clk); #1;
        in_req = 4'h8; in_amo[2] = 4'h0;
        @(negedge clk);
        check("amo_commit_req", 64'(out_req), 64'd0);
        check("amo_commit_gnt", 64'(in_gnt), 64'd0);
        check("amo_rvalid", 64'(in_rvalid), 64'h4);
        check("amo_old_rdata", 64'(in_rdata), 64'hDEADBEEF);
        @(negedge clk);
        check("post_amo_gnt", 64'(in_gnt), 64'h8);
        check("post_amo_rvalid", 64'(in_rvalid), 64'h0);
        @(posedge clk); #1;
        in_req = 4'h0;
        @(negedge clk);
        check("post_amo_ld_rvalid", 64'(in_rvalid), 64'h8);
        check("post_amo_ld_rdata", 64'(in_rdata), 64'hDEADBEF0);

        // Reset asserted during an AMO grant cycle.
        @(posedge clk); #1;
        in_req = 4'h4; in_amo[2] = 4'h2;
        @(negedge clk);
        check("rst_amo_gnt", 64'(in_gnt), 64'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_amo_out_req", 64'(out_req), 64'd0);
        @(posedge clk); #1;
        check("rst_amo_rvalid", 64'(in_rvalid), 64'd0);
        check("rst_amo_rr", 64'(dut.rr_q), 64'd0);
        check("rst_amo_state", 64'(dut.state_q), 64'd0);
        in_req = 4'hF; in_amo[2] = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_rst_gnt", 64'(in_gnt), 64'h1);
        check("after_rst_out_req", 64'(out_req), 64'd1);
        @(posedge clk); #1;
        in_req = 4'h0;
        @(negedge clk);
        check("after_rst_rvalid", 64'(in_rvalid), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
